// File: rtl/axi4_lite_master_if.sv
// AXI4-Lite bus bundle between the register-access initiator and its slave.
// The master modport drives the request channels; the slave modport answers them.
interface axi4_lite_master_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic                  AWVALID;
   logic                  AWREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic                  WVALID;
   logic                  WREADY;
   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWVALID, input AWREADY,
      output WDATA, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARVALID, input ARREADY,
      input RDATA, RRESP, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWVALID, output AWREADY,
      input WDATA, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARVALID, output ARREADY,
      output RDATA, RRESP, RVALID, input RREADY
   );
endinterface

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one local read/write command becomes
// an AW/W/B or AR/R exchange; read data and response code are held for the caller.
module axi4_lite_master #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic                  cmd_start,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  cmd_ready,
   output logic                  cmd_done,
   output logic [DATA_WIDTH-1:0] cmd_rdata,
   output logic [1:0]            cmd_resp,
   axi4_lite_master_if.master    axi
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_WR_RESP = 3'd2,
      S_RD_REQ  = 3'd3,
      S_RD_RESP = 3'd4
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   state_e                state_q, state_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  bready_q, bready_d;
   logic                  arvalid_q, arvalid_d;
   logic                  rready_q, rready_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  done_q, done_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;

   // State register and all registered outputs
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= S_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= ADDR_ZERO;
         araddr_q  <= ADDR_ZERO;
         wdata_q   <= DATA_ZERO;
         done_q    <= 1'b0;
         rdata_q   <= DATA_ZERO;
         resp_q    <= 2'b00;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   // Next-state and next-output logic; everything holds unless a transition says otherwise
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;
      rdata_d   = rdata_q;
      resp_d    = resp_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_start) begin
               if (cmd_write) begin
                  state_d   = S_WR_REQ;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
               end else begin
                  state_d   = S_RD_REQ;
                  arvalid_d = 1'b1;
                  araddr_d  = cmd_addr;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WR_REQ: begin
            // AW and W retire independently; B is only accepted once both are gone
            awvalid_d = awvalid_q & ~axi.AWREADY;
            wvalid_d  = wvalid_q & ~axi.WREADY;
            if (!awvalid_d && !wvalid_d) begin
               state_d  = S_WR_RESP;
               bready_d = 1'b1;
            end else begin
               state_d = S_WR_REQ;
            end
         end
         S_WR_RESP: begin
            if (bready_q && axi.BVALID) begin
               bready_d = 1'b0;
               resp_d   = axi.BRESP;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_WR_RESP;
            end
         end
         S_RD_REQ: begin
            if (arvalid_q && axi.ARREADY) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_RD_RESP;
            end else begin
               state_d = S_RD_REQ;
            end
         end
         S_RD_RESP: begin
            if (rready_q && axi.RVALID) begin
               rready_d = 1'b0;
               rdata_d  = axi.RDATA;
               resp_d   = axi.RRESP;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end else begin
               state_d = S_RD_RESP;
            end
         end
         default: begin
            state_d   = S_IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
         end
      endcase
   end

   assign axi.AWADDR  = awaddr_q;
   assign axi.AWVALID = awvalid_q;
   assign axi.WDATA   = wdata_q;
   assign axi.WVALID  = wvalid_q;
   assign axi.BREADY  = bready_q;
   assign axi.ARADDR  = araddr_q;
   assign axi.ARVALID = arvalid_q;
   assign axi.RREADY  = rready_q;

   assign cmd_ready = (state_q == S_IDLE);
   assign cmd_done  = done_q;
   assign cmd_rdata = rdata_q;
   assign cmd_resp  = resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: a delay-programmable register slave answers the bus,
// and a scoreboard queue holds the expected response/read data of each command.
module tb_axi4_lite_master;

   logic        ACLK;
   logic        ARESETn;
   logic        cmd_start;
   logic        cmd_write;
   logic [3:0]  cmd_addr;
   logic [31:0] cmd_wdata;
   logic        cmd_ready;
   logic        cmd_done;
   logic [31:0] cmd_rdata;
   logic [1:0]  cmd_resp;

   axi4_lite_master_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) axi_if ();

   axi4_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK      (ACLK),
      .ARESETn   (ARESETn),
      .cmd_start (cmd_start),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_ready (cmd_ready),
      .cmd_done  (cmd_done),
      .cmd_rdata (cmd_rdata),
      .cmd_resp  (cmd_resp),
      .axi       (axi_if.master)
   );

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   int          base_done = 0;
   int          viol = 0;
   int          aw_cycles = 0;
   int          w_cycles = 0;
   int          w_unstable = 0;
   logic [31:0] exp_rdata = 32'h0;

   // slave configuration and memory
   int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;
   logic [31:0] rdata_v = 32'h0;
   logic [31:0] mem [4];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   always @(posedge ACLK) cyc <= cyc + 1;

   // Slave model: decides READY/VALID on the falling edge, so a READY seen high
   // at a falling edge means the handshake completed on the rising edge before it.
   initial begin
      int  aw_cnt, w_cnt, ar_cnt, r_cnt;
      bit  got_aw, got_w, got_ar, last_bready, last_rready;
      logic [3:0]  cap_addr;
      logic [31:0] cap_data;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
      got_aw = 0; got_w = 0; got_ar = 0; last_bready = 0; last_rready = 0;
      cap_addr = 4'h0; cap_data = 32'h0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h0;
      axi_if.AWREADY = 1'b0; axi_if.WREADY = 1'b0; axi_if.ARREADY = 1'b0;
      axi_if.BVALID = 1'b0; axi_if.BRESP = 2'b00;
      axi_if.RVALID = 1'b0; axi_if.RRESP = 2'b00; axi_if.RDATA = 32'h0;
      forever begin
         @(negedge ACLK);
         if (!ARESETn) begin
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0;
            got_aw = 0; got_w = 0; got_ar = 0; last_bready = 0; last_rready = 0;
            axi_if.AWREADY = 1'b0; axi_if.WREADY = 1'b0; axi_if.ARREADY = 1'b0;
            axi_if.BVALID = 1'b0; axi_if.RVALID = 1'b0;
         end else begin
            if (axi_if.AWREADY) begin
               got_aw = 1; axi_if.AWREADY = 1'b0; aw_cnt = 0;
            end else if (axi_if.AWVALID && !got_aw) begin
               if (aw_cnt >= aw_dly) begin
                  axi_if.AWREADY = 1'b1; cap_addr = axi_if.AWADDR;
               end else aw_cnt++;
            end
            if (axi_if.WREADY) begin
               got_w = 1; axi_if.WREADY = 1'b0; w_cnt = 0;
            end else if (axi_if.WVALID && !got_w) begin
               if (w_cnt >= w_dly) begin
                  axi_if.WREADY = 1'b1; cap_data = axi_if.WDATA;
               end else w_cnt++;
            end
            if (axi_if.BVALID && last_bready) axi_if.BVALID = 1'b0;
            if (got_aw && got_w) begin
               mem[cap_addr[3:2]] = cap_data;
               axi_if.BVALID = 1'b1; axi_if.BRESP = bresp_v;
               got_aw = 0; got_w = 0;
            end
            if (axi_if.ARREADY) begin
               got_ar = 1; axi_if.ARREADY = 1'b0; ar_cnt = 0; r_cnt = 0;
            end else if (axi_if.ARVALID && !got_ar) begin
               if (ar_cnt >= ar_dly) axi_if.ARREADY = 1'b1;
               else ar_cnt++;
            end
            if (axi_if.RVALID && last_rready) axi_if.RVALID = 1'b0;
            if (got_ar) begin
               if (r_cnt >= r_dly) begin
                  axi_if.RVALID = 1'b1; axi_if.RDATA = rdata_v; axi_if.RRESP = rresp_v;
                  got_ar = 0;
               end else r_cnt++;
            end
            last_bready = axi_if.BREADY;
            last_rready = axi_if.RREADY;
         end
      end
   end

   // Monitor: protocol ordering, payload stability, VALID durations, scoreboard pop
   initial begin
      bit          prev_wvalid;
      logic [31:0] prev_wdata;
      exp_t        e;
      prev_wvalid = 0; prev_wdata = 32'h0;
      forever begin
         @(negedge ACLK);
         if (ARESETn) begin
            if (axi_if.RREADY && axi_if.ARVALID) viol++;
            if (axi_if.BREADY && (axi_if.AWVALID || axi_if.WVALID)) viol++;
            if (axi_if.WVALID && prev_wvalid && axi_if.WDATA !== prev_wdata) w_unstable++;
            if (axi_if.AWVALID) aw_cycles++;
            if (axi_if.WVALID) w_cycles++;
            prev_wvalid = axi_if.WVALID;
            prev_wdata  = axi_if.WDATA;
            if (cmd_done) begin
               done_cnt++;
               done_cyc = cyc;
               if (sb_q.size() == 0) begin
                  check_eq("sb_unexpected_done", 64'd1, 64'd0);
               end else begin
                  e = sb_q.pop_front();
                  check_eq("sb_resp", {62'd0, cmd_resp}, {62'd0, e.resp});
                  check_eq("sb_rdata", {32'd0, cmd_rdata}, {32'd0, e.rdata});
               end
            end
         end else begin
            prev_wvalid = 0;
         end
      end
   end

   task automatic issue(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                        input logic [1:0] eresp, input logic [31:0] erd);
      exp_t e;
      int   i;
      i = 0;
      while (!cmd_ready && i < 100) begin
         @(negedge ACLK); #1; i++;
      end
      if (!cmd_ready) check_eq("issue_ready_timeout", 64'd0, 64'd1);
      if (!wr) exp_rdata = erd;
      e.resp = eresp; e.rdata = exp_rdata;
      sb_q.push_back(e);
      cmd_start = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
      start_cyc = cyc;
      base_done = done_cnt;
      @(negedge ACLK);
      cmd_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      int i;
      i = 0;
      while (done_cnt == base_done && i < 200) begin
         @(negedge ACLK); #1; i++;
      end
      if (done_cnt == base_done) check_eq("done_timeout", 64'd0, 64'd1);
      lat = done_cyc - start_cyc + 1;
   endtask

   task automatic check_reset_vals();
      check_eq("rst_valids", {59'd0, axi_if.AWVALID, axi_if.WVALID, axi_if.ARVALID,
                              axi_if.BREADY, axi_if.RREADY}, 64'd0);
      check_eq("rst_addr_data", {24'd0, axi_if.AWADDR, axi_if.ARADDR, axi_if.WDATA}, 64'd0);
      check_eq("rst_ready_done", {62'd0, cmd_ready, cmd_done}, 64'd2);
      check_eq("rst_rdata_resp", {30'd0, cmd_rdata, cmd_resp}, 64'd0);
   endtask

   initial begin
      int lat, base;
      ARESETn = 1'b0; cmd_start = 1'b0; cmd_write = 1'b0;
      cmd_addr = 4'h0; cmd_wdata = 32'h0;
      repeat (3) @(negedge ACLK);
      #1 check_reset_vals();
      ARESETn = 1'b1;
      repeat (2) @(negedge ACLK);

      // T1: always-ready write
      aw_cycles = 0; w_cycles = 0;
      issue(1'b1, 4'h4, 32'hDEADBEEF, 2'b00, 32'h0);
      wait_done(lat);
      check_eq("t1_latency", lat, 64'd4);
      check_eq("t1_aw_cycles", aw_cycles, 64'd1);
      check_eq("t1_w_cycles", w_cycles, 64'd1);
      check_eq("t1_reg1", {32'd0, mem[1]}, 64'hDEADBEEF);

      // T2: W handshake delayed 3 cycles
      w_dly = 3; aw_cycles = 0; w_cycles = 0; w_unstable = 0;
      issue(1'b1, 4'hC, 32'hA5A5A5A5, 2'b00, 32'h0);
      wait_done(lat);
      check_eq("t2_aw_cycles", aw_cycles, 64'd1);
      check_eq("t2_w_cycles", w_cycles, 64'd4);
      check_eq("t2_w_stable", w_unstable, 64'd0);
      check_eq("t2_reg3", {32'd0, mem[3]}, 64'hA5A5A5A5);
      w_dly = 0;

      // T3: slow read
      ar_dly = 2; r_dly = 5; rdata_v = 32'h12345678; rresp_v = 2'b00;
      issue(1'b0, 4'h8, 32'h0, 2'b00, 32'h12345678);
      #1 check_eq("t3_arvalid_rready", {62'd0, axi_if.ARVALID, axi_if.RREADY}, 64'd2);
      check_eq("t3_araddr", {60'd0, axi_if.ARADDR}, 64'h8);
      wait_done(lat);
      ar_dly = 0; r_dly = 0;

      // fast read: latency
      rdata_v = 32'h0F0F1234;
      issue(1'b0, 4'h0, 32'h0, 2'b00, 32'h0F0F1234);
      wait_done(lat);
      check_eq("rd_latency", lat, 64'd4);

      // T4: error responses; write must not disturb cmd_rdata
      bresp_v = 2'b10;
      issue(1'b1, 4'h8, 32'h11112222, 2'b10, 32'h0);
      wait_done(lat);
      bresp_v = 2'b00; rresp_v = 2'b11; rdata_v = 32'hCAFEF00D;
      issue(1'b0, 4'h4, 32'h0, 2'b11, 32'hCAFEF00D);
      wait_done(lat);
      rresp_v = 2'b00;

      // T5: starts while busy are ignored; start on the done cycle is taken
      ar_dly = 3; r_dly = 4; rdata_v = 32'h0BADC0DE;
      issue(1'b0, 4'h8, 32'h0, 2'b00, 32'h0BADC0DE);
      base = base_done;
      for (int k = 0; k < 3; k++) begin
         @(negedge ACLK);
         check_eq("t5_busy", {63'd0, cmd_ready}, 64'd0);
         cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'hFFFF0000;
         @(negedge ACLK);
         cmd_start = 1'b0;
      end
      begin
         int i;
         exp_t e;
         i = 0;
         while (done_cnt == base && i < 200) begin
            @(negedge ACLK); #1; i++;
         end
         check_eq("t5_done_ready", {62'd0, cmd_done, cmd_ready}, 64'd3);
         e.resp = 2'b00; e.rdata = exp_rdata;
         sb_q.push_back(e);
         cmd_start = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 32'h600DF00D;
         start_cyc = cyc; base_done = done_cnt;
         @(negedge ACLK); #1;
         cmd_start = 1'b0;
         check_eq("t5_awvalid_next", {63'd0, axi_if.AWVALID}, 64'd1);
         check_eq("t5_one_done", done_cnt - base, 64'd1);
      end
      wait_done(lat);
      check_eq("t5_no_stray_write", {32'd0, mem[0]}, 64'd0);
      check_eq("t5_reg1", {32'd0, mem[1]}, 64'h600DF00D);
      ar_dly = 0; r_dly = 0;

      // T6: reset while W is pending
      w_dly = 10;
      issue(1'b1, 4'h0, 32'h77778888, 2'b00, 32'h0);
      @(negedge ACLK); #1;
      check_eq("t6_wvalid_pending", {63'd0, axi_if.WVALID}, 64'd1);
      #1 ARESETn = 1'b0;
      #1 check_reset_vals();
      sb_q.delete();
      exp_rdata = 32'h0;
      base = done_cnt;
      repeat (3) @(negedge ACLK);
      check_eq("t6_no_done", done_cnt - base, 64'd0);
      ARESETn = 1'b1;
      w_dly = 0;
      @(negedge ACLK);
      issue(1'b1, 4'h0, 32'h13572468, 2'b00, 32'h0);
      wait_done(lat);
      check_eq("t6_latency", lat, 64'd4);
      check_eq("t6_reg0", {32'd0, mem[0]}, 64'h13572468);

      repeat (3) @(negedge ACLK);
      check_eq("sb_empty", sb_q.size(), 64'd0);
      check_eq("proto_order", viol, 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
